sensor_scan_seq: RTL

- Sequencer directly upstream of A2D_intf and downstream of its results.
- On each scan request it walks IR line-sensor channels 0..5: selects `chnnl`, waits a settle time, pulses `strt_cnv`, then captures `res` when `cnv_cmplt` rises.
- After six readings it produces a signed weighted line-position error and a line-lost flag for the steering controller.
- A watchdog aborts the scan if the A2D interface stalls.

---
 rtl/a2d_pkg.sv | 30 +++
 rtl/sensor_wsum_acc.sv | 34 +++
 rtl/sensor_scan_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/a2d_pkg.sv
// Shared types and constants for the IR line-sensor scan sequencer.
// Channel weights are realised as a shift plus optional negate.
package a2d_pkg;

    localparam int NUM_SENS = 6;
    localparam int RES_W    = 12;
    localparam int ACC_W    = 16;

    typedef logic [RES_W-1:0] res_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_ACCUM,
        S_DONE
    } state_e;

    // Entry 0 is ch0: weights -4,-2,-1,+1,+2,+4 across the array
    localparam logic [NUM_SENS-1:0][1:0] W_SHIFT = {2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2};
    localparam logic [NUM_SENS-1:0]      W_NEG   = 6'b000111;

    function automatic logic signed [ACC_W-1:0] weigh(input logic [2:0] idx, input res_t r);
        logic signed [ACC_W-1:0] mag;
        mag = $signed({{(ACC_W-RES_W){1'b0}}, r}) <<< W_SHIFT[idx];
        return W_NEG[idx] ? -mag : mag;
    endfunction

endpackage

// File: rtl/sensor_wsum_acc.sv
// Registered signed accumulator of weighted sensor readings.
// clear wins over add_en; |sum| stays well inside 16 bits so no saturation.
module sensor_wsum_acc
    import a2d_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    add_en,
    input  logic [2:0]              idx,
    input  logic [RES_W-1:0]        res,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear)
            acc_d = '0;
        else if (add_en)
            acc_d = acc_q + weigh(idx, res);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/sensor_scan_seq.sv
// Walks IR sensor channels 0..5 through the A2D interface and reports a
// weighted line-position error, line-lost and timeout-fault per scan.
module sensor_scan_seq
    import a2d_pkg::*;
#(
    parameter int unsigned SETTLE  = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [11:0] THRESH  = 12'h200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_go,
    output logic        busy,
    output logic [2:0]  chnnl,
    output logic        strt_cnv,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        scan_done,
    output logic [15:0] err,
    output logic        line_lost,
    output logic        fault
);

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [2:0]       CH_LAST  = 3'(NUM_SENS - 1);

    state_e            state_q, state_d;
    logic [2:0]        chnnl_q, chnnl_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              cnv_q;
    logic              lost_q, lost_d;
    logic              abort_q, abort_d;
    logic [15:0]       err_q, err_d;
    logic              line_lost_q, line_lost_d;
    logic              fault_q, fault_d;
    logic              acc_clr, acc_add;
    logic signed [ACC_W-1:0] acc;
    logic              cnv_rise;

    // A level left high from an earlier conversion must not count as complete
    assign cnv_rise = cnv_cmplt & ~cnv_q;

    always_comb begin
        state_d  = state_q;
        chnnl_d  = chnnl_q;
        settle_d = settle_q;
        to_d     = '0;
        lost_d   = lost_q;
        abort_d  = abort_q;
        acc_clr  = 1'b0;
        acc_add  = 1'b0;
        case (state_q)
            S_IDLE: if (scan_go) begin
                chnnl_d  = '0;
                settle_d = '0;
                lost_d   = 1'b1;
                abort_d  = 1'b0;
                acc_clr  = 1'b1;
                state_d  = S_SETTLE;
            end
            S_SETTLE: if (settle_q == SET_LAST) begin
                settle_d = '0;
                state_d  = S_START;
            end else begin
                settle_d = settle_q + SET_W'(1);
            end
            // Watchdog counts from the strt_cnv cycle, so abort lands TIMEOUT cycles later
            S_START: begin
                to_d    = to_q + TO_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: if (cnv_rise) begin
                state_d = S_ACCUM;
            end else if (to_q == TO_LAST) begin
                abort_d = 1'b1;
                state_d = S_DONE;
            end else begin
                to_d = to_q + TO_W'(1);
            end
            S_ACCUM: begin
                acc_add = 1'b1;
                lost_d  = lost_q & (res < THRESH);
                if (chnnl_q == CH_LAST) begin
                    state_d = S_DONE;
                end else begin
                    chnnl_d = chnnl_q + 3'd1;
                    state_d = S_SETTLE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Result outputs take their new value during DONE and hold afterwards
    always_comb begin
        err_d       = err_q;
        line_lost_d = line_lost_q;
        fault_d     = fault_q;
        if (state_q == S_DONE) begin
            err_d       = abort_q ? err_q : 16'(acc);
            line_lost_d = lost_q & ~abort_q;
            fault_d     = abort_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            chnnl_q     <= '0;
            settle_q    <= '0;
            to_q        <= '0;
            cnv_q       <= 1'b0;
            lost_q      <= 1'b0;
            abort_q     <= 1'b0;
            err_q       <= '0;
            line_lost_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            chnnl_q     <= chnnl_d;
            settle_q    <= settle_d;
            to_q        <= to_d;
            cnv_q       <= cnv_cmplt;
            lost_q      <= lost_d;
            abort_q     <= abort_d;
            err_q       <= err_d;
            line_lost_q <= line_lost_d;
            fault_q     <= fault_d;
        end
    end

    sensor_wsum_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clr),
        .add_en (acc_add),
        .idx    (chnnl_q),
        .res    (res),
        .acc    (acc)
    );

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign chnnl     = chnnl_q;
    assign strt_cnv  = (state_q == S_START);
    assign scan_done = (state_q == S_DONE);
    assign err       = err_d;
    assign line_lost = line_lost_d;
    assign fault     = fault_d;

endmodule
